// File: rtl/result_tx_buffer.sv
// result_tx_buffer
//   Output side of the accelerator datapath. Takes 8-lane signed int8
//   convolution results, re-applies the output zero point to make uint8 lanes,
//   buffers the words and sends them back to the DMA/PS as a valid/ready 64-bit
//   stream. The stream carries a last flag that marks the end of each frame.
//
//   Build option: define RESULT_TX_SAT_EN to clamp each lane to [0,255].
//   When it is undefined, each lane wraps modulo 256. Wrapping is the exact
//   inverse of the subtract done on the input side.
//
// Ports
//   sclk, s_rst        clock and synchronous active-high reset
//   result_wr_en       result word write strobe
//   result_wr_data     lane k = bits[8k+7:8k], signed int8
//   zero_point_out     uint8 zero point, sampled with each accepted word
//   cfg_frame_len      beats per frame (0 is treated as 1), latched between frames
//   stream_tx_*        64-bit valid/ready stream with frame last
//   result_full        occupancy == DEPTH
//   result_empty       occupancy == 0
//   result_data_count  words held: stage register + memory + output register
//   result_overflow    sticky flag, set by a write while full; ovf_clr clears it
module result_tx_buffer #(
  parameter int DEPTH = 4096,
  parameter int CNT_W = 13
) (
  input  logic             sclk,
  input  logic             s_rst,
  input  logic             result_wr_en,
  input  logic [63:0]      result_wr_data,
  input  logic [7:0]       zero_point_out,
  input  logic [15:0]      cfg_frame_len,
  output logic [63:0]      stream_tx_data,
  output logic             stream_tx_vld,
  input  logic             stream_tx_rdy,
  output logic             stream_tx_last,
  output logic             result_full,
  output logic             result_empty,
  output logic [CNT_W-1:0] result_data_count,
  output logic             result_overflow,
  input  logic             ovf_clr
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_e;

  // Requantize one lane: signed result plus unsigned zero point.
  function automatic logic [7:0] requant_lane(input logic [7:0] res, input logic [7:0] zp);
`ifdef RESULT_TX_SAT_EN
    logic [9:0] sum;
    sum = {{2{res[7]}}, res} + {2'b00, zp};
    if (sum[9]) begin
      return 8'h00;
    end else if (sum[8]) begin
      return 8'hFF;
    end else begin
      return sum[7:0];
    end
`else
    return res + zp;
`endif
  endfunction

  // Requantize all eight lanes of a result word.
  function automatic logic [63:0] requant_word(input logic [63:0] res, input logic [7:0] zp);
    logic [63:0] w;
    w = 64'd0;
    for (int k = 0; k < 8; k++) begin
      w[8*k +: 8] = requant_lane(res[8*k +: 8], zp);
    end
    return w;
  endfunction

  logic [63:0]      mem [0:DEPTH-1];

  state_e           state_q, state_d;
  logic             stg_vld_q, stg_vld_d;
  logic [63:0]      stg_data_q, stg_data_d;
  logic             out_vld_q, out_vld_d;
  logic [63:0]      out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      beat_cnt_q, beat_cnt_d;
  logic [15:0]      frame_len_q, frame_len_d;

  logic             accept;
  logic             hs;
  logic             mem_empty;
  logic             out_load;
  logic             mem_we;
  logic             last_now;
  logic [15:0]      cfg_len_eff;

  // Next-state logic for the datapath, occupancy, overflow and frame FSM.
  always_comb begin
    state_d     = state_q;
    stg_vld_d   = 1'b0;
    stg_data_d  = stg_data_q;
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    beat_cnt_d  = beat_cnt_q;
    frame_len_d = frame_len_q;

    accept      = result_wr_en && !full_q;
    hs          = out_vld_q && stream_tx_rdy;
    mem_empty   = (wr_ptr_q == rd_ptr_q);
    out_load    = !out_vld_q || hs;
    cfg_len_eff = (cfg_frame_len == 16'd0) ? 16'd1 : cfg_frame_len;
    last_now    = (beat_cnt_q == (frame_len_q - 16'd1));

    // Stage 1: requantize on accept.
    if (accept) begin
      stg_vld_d  = 1'b1;
      stg_data_d = requant_word(result_wr_data, zero_point_out);
    end else begin
      stg_vld_d  = 1'b0;
    end

    // The stage bypasses the memory only when the memory is empty and the
    // output register is free. Otherwise the word joins the memory behind
    // older words.
    mem_we = stg_vld_q && !(out_load && mem_empty);
    if (mem_we) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    // First-word-fall-through output register: refilled whenever it is empty
    // or being consumed, so buffered data streams out without bubbles.
    if (out_load) begin
      if (!mem_empty) begin
        out_vld_d  = 1'b1;
        out_data_d = mem[rd_ptr_q];
        rd_ptr_d   = rd_ptr_q + AW'(1);
      end else if (stg_vld_q) begin
        out_vld_d  = 1'b1;
        out_data_d = stg_data_q;
      end else begin
        out_vld_d  = 1'b0;
      end
    end else begin
      out_vld_d = out_vld_q;
    end

    case ({accept, hs})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A new overflow wins over a clear in the same cycle.
    if (result_wr_en && full_q) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    // Frame length is sampled only while no beat is presented at count 0,
    // or on the closing handshake. last therefore never changes under a stall.
    case (state_q)
      ST_IDLE: begin
        if (!out_vld_q) begin
          frame_len_d = cfg_len_eff;
        end else if (hs) begin
          if (last_now) begin
            beat_cnt_d  = 16'd0;
            frame_len_d = cfg_len_eff;
          end else begin
            beat_cnt_d = beat_cnt_q + 16'd1;
            state_d    = ST_SEND;
          end
        end else begin
          frame_len_d = frame_len_q;
        end
      end
      ST_SEND: begin
        if (hs) begin
          if (last_now) begin
            beat_cnt_d  = 16'd0;
            frame_len_d = cfg_len_eff;
            state_d     = ST_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 16'd1;
          end
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        beat_cnt_d = 16'd0;
      end
    endcase

    full_d     = (count_d == CNT_W'(DEPTH));
    empty_d    = (count_d == {CNT_W{1'b0}});
    out_last_d = out_vld_d && (beat_cnt_d == (frame_len_d - 16'd1));
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state_q     <= ST_IDLE;
      stg_vld_q   <= 1'b0;
      stg_data_q  <= 64'd0;
      out_vld_q   <= 1'b0;
      out_data_q  <= 64'd0;
      out_last_q  <= 1'b0;
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      ovf_q       <= 1'b0;
      beat_cnt_q  <= 16'd0;
      frame_len_q <= 16'd1;
    end else begin
      state_q     <= state_d;
      stg_vld_q   <= stg_vld_d;
      stg_data_q  <= stg_data_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      ovf_q       <= ovf_d;
      beat_cnt_q  <= beat_cnt_d;
      frame_len_q <= frame_len_d;
    end
  end

  // Buffer memory write port; contents are don't-care after reset.
  always_ff @(posedge sclk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= stg_data_q;
    end
  end

  assign stream_tx_data    = out_data_q;
  assign stream_tx_vld     = out_vld_q;
  assign stream_tx_last    = out_last_q;
  assign result_full       = full_q;
  assign result_empty      = empty_q;
  assign result_data_count = count_q;
  assign result_overflow   = ovf_q;

endmodule
